// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter.
//
// Contents:
//   DefDataSize, DefAddressSize, DefNumReq : default widths and producer count
//   arb_state_e                            : arbiter state (IDLE, LOCKED)
//   id_width()                             : width of a producer index for n producers

package fifo_pkg;

  localparam int unsigned DefDataSize    = 8;
  localparam int unsigned DefAddressSize = 4;
  localparam int unsigned DefNumReq      = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Producer index width; never zero so a single-producer build still elaborates.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin winner search.
//
// The search starts at last_grant+1 and wraps modulo NUM_REQ, so the most
// recent owner has the lowest priority on the next arbitration.
//
// Ports:
//   req        in   NUM_REQ  request vector
//   last_grant in   ID_W     index of the previous owner
//   winner     out  ID_W     index of the selected requester (0 when none)
//   any        out  1        at least one request is pending

module fifo_rr_pick
  import fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  logic            found_hi;
  logic            found_lo;
  logic [ID_W-1:0] win_hi;
  logic [ID_W-1:0] win_lo;

  // Split requesters into those above last_grant (searched first) and those at
  // or below it (the wrapped part). Scanning downwards leaves the lowest index
  // of each region, which is the nearest one in search order.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (ID_W'(i) > last_grant) begin
          found_hi = 1'b1;
          win_hi   = ID_W'(i);
        end else begin
          found_lo = 1'b1;
          win_lo   = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    winner = found_hi ? win_hi : win_lo;
    any    = found_hi | found_lo;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-granular write arbiter in front of an async FIFO write port.
//
// Several producers compete for the FIFO write side. A round-robin winner is
// locked in for a whole packet (until a transferred beat carries req_last),
// then the block returns to IDLE for one bubble cycle before re-arbitrating.
// The binary write pointer (with wrap bit) is kept here and exported for the
// full-flag / Gray-code logic.
//
// Ports:
//   wclk       in   1                   clock, rising edge
//   wrst       in   1                   synchronous active-high reset
//   req_valid  in   NUM_REQ             producer i presents a beat
//   req_last   in   NUM_REQ             producer i's beat ends its packet
//   req_data   in   NUM_REQ*DATA_SIZE   producer i word at [i*DATA_SIZE +: DATA_SIZE]
//   req_ready  out  NUM_REQ             producer i's beat is accepted this cycle
//   wfull      in   1                   FIFO full flag
//   winc       out  1                   memory write strobe
//   waddr      out  ADDRESS_SIZE        memory write address
//   wdata      out  DATA_SIZE           memory write data
//   wptr_bin   out  ADDRESS_SIZE+1      binary write pointer including wrap bit
//   grant_id   out  clog2(NUM_REQ)      index of the current owner
//   busy       out  1                   high while LOCKED

module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = DefDataSize,
  parameter int unsigned ADDRESS_SIZE = DefAddressSize,
  parameter int unsigned NUM_REQ      = DefNumReq
) (
  input  logic                           wclk,
  input  logic                           wrst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           wfull,
  output logic                           winc,
  output logic [ADDRESS_SIZE-1:0]        waddr,
  output logic [DATA_SIZE-1:0]           wdata,
  output logic [ADDRESS_SIZE:0]          wptr_bin,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned PtrW = ADDRESS_SIZE + 1;

  arb_state_e      state_q, state_d;
  logic [IdW-1:0]  grant_q, grant_d;
  logic [IdW-1:0]  last_q, last_d;
  logic [PtrW-1:0] wptr_q, wptr_d;

  logic [IdW-1:0]       pick_id;
  logic                 pick_any;
  logic                 own_valid;
  logic                 own_last;
  logic [DATA_SIZE-1:0] own_data;
  logic                 xfer;

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (IdW)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_q),
    .winner     (pick_id),
    .any        (pick_any)
  );

  // Owner-side view of the request bus.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IdW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  // A beat moves only when the owner is valid and the FIFO has room.
  assign xfer = (state_q == LOCKED) && own_valid && !wfull;

  // State register.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IdW'(NUM_REQ - 1);
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wptr_q  <= wptr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wptr_d  = wptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = LOCKED;
          grant_d = pick_id;
        end
      end
      LOCKED: begin
        // No timeout: a stalled owner keeps the grant until its last beat.
        if (xfer) begin
          wptr_d = wptr_q + PtrW'(1);
          if (own_last) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Strobes are masked by wrst so nothing is accepted or written
  // during the reset cycle, even before the state register is initialised.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == LOCKED) && (grant_q == IdW'(i)) && !wfull && !wrst;
    end
    winc     = xfer && !wrst;
    waddr    = wrst ? '0 : wptr_q[ADDRESS_SIZE-1:0];
    wdata    = own_data;
    wptr_bin = wptr_q;
    grant_id = grant_q;
    busy     = (state_q == LOCKED) && !wrst;
  end

endmodule
